// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 size codes, exception causes,
// the latched request record and the request legality check.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;

  localparam logic [3:0] EXC_NONE        = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } lsu_req_t;

  // Returns EXC_NONE for a request that may go to the bus; illegal wins over misaligned.
  function automatic logic [3:0] lsu_check(input logic       is_load,
                                           input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal = (is_load == is_store) ||
              (is_load  && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) ||
              (is_store && (funct3 > LSU_W));
    misaligned = ((funct3 == LSU_H || funct3 == LSU_HU) && off[0]) ||
                 ((funct3 == LSU_W) && (off != 2'b00));
    if (illegal)
      return EXC_ILLEGAL;
    else if (misaligned)
      return is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
    else
      return EXC_NONE;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store data replication and strobes on the request side,
// load lane extraction and sign/zero extension on the response side.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wstrb,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_funct3)
      LSU_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_off;
      end
      LSU_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      LSU_B:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LSU_H:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      LSU_BU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      LSU_HU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one req/ack data-memory transaction per accepted
// request, with one-cycle done, writeback and exception pulses.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_wstrb,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_done,
  output logic            o_exc_valid,
  output logic [3:0]      o_exc_cause,
  output logic [XLEN-1:0] o_exc_tval
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_EXC  = 2'd3;

  logic [1:0]      state;
  lsu_req_t        req_q;
  logic [3:0]      req_cause;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] ld_data;

  assign o_ready   = (state == S_IDLE);
  assign req_cause = lsu_check(i_is_load, i_is_store, i_funct3, i_addr[1:0]);

  // Store lanes come from the live request; load lanes from the latched one.
  lsu_align u_align (
    .st_funct3 (i_funct3),
    .st_off    (i_addr[1:0]),
    .st_data   (i_store_data),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (req_q.funct3),
    .ld_off    (req_q.off),
    .ld_rdata  (i_mem_rdata),
    .ld_data   (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      req_q       <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_rd     <= '0;
      o_wb_data   <= '0;
      o_done      <= 1'b0;
      o_exc_valid <= 1'b0;
      o_exc_cause <= '0;
      o_exc_tval  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            req_q <= '{is_load: i_is_load, funct3: i_funct3,
                       off: i_addr[1:0], rd: i_rd};
            if (req_cause != EXC_NONE) begin
              state       <= S_EXC;
              o_done      <= 1'b1;
              o_exc_valid <= 1'b1;
              o_exc_cause <= req_cause;
              o_exc_tval  <= i_addr;
            end else begin
              state       <= S_MEM;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_is_store;
              o_mem_addr  <= {i_addr[XLEN-1:2], 2'b00};
              o_mem_wdata <= i_is_store ? st_wdata : '0;
              o_mem_wstrb <= i_is_store ? st_wstrb : 4'b0000;
            end
          end
        end
        S_MEM: begin
          if (i_mem_ack) begin
            state       <= S_DONE;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            o_done      <= 1'b1;
            // Writes to x0 are dropped entirely, so the wb bus stays zero.
            if (req_q.is_load && (req_q.rd != 5'd0)) begin
              o_wb_valid <= 1'b1;
              o_wb_rd    <= req_q.rd;
              o_wb_data  <= ld_data;
            end
          end
        end
        S_DONE, S_EXC: begin
          state       <= S_IDLE;
          o_done      <= 1'b0;
          o_wb_valid  <= 1'b0;
          o_wb_rd     <= '0;
          o_wb_data   <= '0;
          o_exc_valid <= 1'b0;
          o_exc_cause <= '0;
          o_exc_tval  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions plus
// hand-written back-to-back and reset-during-bus-request sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_load;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_done;
  logic        o_exc_valid;
  logic [3:0]  o_exc_cause;
  logic [31:0] o_exc_tval;

  load_store_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_is_load    (i_is_load),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .i_rd         (i_rd),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wstrb  (o_mem_wstrb),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_done       (o_done),
    .o_exc_valid  (o_exc_valid),
    .o_exc_cause  (o_exc_cause),
    .o_exc_tval   (o_exc_tval)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          delay;
    logic [3:0]  cause;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wb;
    logic [31:0] wbdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input int delay, input logic [3:0] cause,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic wb, input logic [31:0] wbdata);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata;
    v.rdata = rdata; v.rd = rd; v.delay = delay; v.cause = cause;
    v.wdata = wdata; v.wstrb = wstrb; v.wb = wb; v.wbdata = wbdata;
    return v;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (o_ready) return;
      @(negedge i_clk);
    end
    check("ready_wait_timeout", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] rd);
    i_valid      = 1'b1;
    i_is_load    = ld;
    i_is_store   = st;
    i_funct3     = f3;
    i_addr       = addr;
    i_store_data = sdata;
    i_rd         = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_ready();
    drive_req(v.ld, v.st, v.f3, v.addr, v.sdata, v.rd);
    @(negedge i_clk);
    // Scramble the request inputs to prove the fields were latched.
    drive_req(~v.ld, ~v.st, 3'd7, 32'hFFFF_FFFC, ~v.sdata, ~v.rd);
    i_valid = 1'b0;
    check({p, "_ready_busy"}, {31'd0, o_ready}, 32'd0);
    if (v.cause != EXC_NONE) begin
      check({p, "_exc_valid"}, {31'd0, o_exc_valid}, 32'd1);
      check({p, "_exc_cause"}, {28'd0, o_exc_cause}, {28'd0, v.cause});
      check({p, "_exc_tval"}, o_exc_tval, v.addr);
      check({p, "_exc_done"}, {31'd0, o_done}, 32'd1);
      check({p, "_exc_no_req"}, {31'd0, o_mem_req}, 32'd0);
      check({p, "_exc_no_wb"}, {31'd0, o_wb_valid}, 32'd0);
      @(negedge i_clk);
      check({p, "_exc_clear"}, {31'd0, o_exc_valid}, 32'd0);
      check({p, "_exc_cause_clear"}, {28'd0, o_exc_cause}, 32'd0);
      check({p, "_exc_done_clear"}, {31'd0, o_done}, 32'd0);
      check({p, "_exc_no_req2"}, {31'd0, o_mem_req}, 32'd0);
      check({p, "_exc_ready"}, {31'd0, o_ready}, 32'd1);
    end else begin
      check({p, "_we"}, {31'd0, o_mem_we}, {31'd0, v.st});
      check({p, "_wstrb"}, {28'd0, o_mem_wstrb}, {28'd0, v.wstrb});
      if (v.st) check({p, "_wdata"}, o_mem_wdata, v.wdata);
      check({p, "_no_early_done"}, {31'd0, o_done}, 32'd0);
      for (int k = 1; k <= v.delay; k++) begin
        check({p, "_req_held"}, {31'd0, o_mem_req}, 32'd1);
        check({p, "_addr"}, o_mem_addr, v.addr & 32'hFFFF_FFFC);
        if (k == v.delay) begin
          i_mem_rdata = v.rdata;
          i_mem_ack   = 1'b1;
        end
        @(negedge i_clk);
      end
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h0BAD_0BAD;
      check({p, "_done"}, {31'd0, o_done}, 32'd1);
      check({p, "_req_drop"}, {31'd0, o_mem_req}, 32'd0);
      check({p, "_wb_valid"}, {31'd0, o_wb_valid}, {31'd0, v.wb});
      check({p, "_wb_rd"}, {27'd0, o_wb_rd}, v.wb ? {27'd0, v.rd} : 32'd0);
      check({p, "_wb_data"}, o_wb_data, v.wb ? v.wbdata : 32'd0);
      check({p, "_no_exc"}, {31'd0, o_exc_valid}, 32'd0);
      check({p, "_ready_done"}, {31'd0, o_ready}, 32'd0);
      @(negedge i_clk);
      check({p, "_done_clear"}, {31'd0, o_done}, 32'd0);
      check({p, "_wb_clear"}, {31'd0, o_wb_valid}, 32'd0);
      check({p, "_ready_back"}, {31'd0, o_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             ld st f3 addr          sdata         rdata         rd dly cause wdata         wstrb   wb wbdata
    vecs.push_back(mk(1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 5, 3, 4'd0, 32'h0,        4'b0000, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'd0, 32'h103, 32'h0,        32'h80112233, 7, 1, 4'd0, 32'h0,        4'b0000, 1, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 3'd4, 32'h103, 32'h0,        32'h80112233, 8, 2, 4'd0, 32'h0,        4'b0000, 1, 32'h00000080));
    vecs.push_back(mk(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        1, 1, 4'd0, 32'hABCDABCD, 4'b1100, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        5, 1, 4'd4, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd3, 32'h200, 32'h55,       32'h0,        1, 1, 4'd2, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd2, 32'h008, 32'h0,        32'h00000055, 0, 1, 4'd0, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h102, 32'h0,        32'h80112233, 9, 1, 4'd0, 32'h0,        4'b0000, 1, 32'hFFFF8011));
    vecs.push_back(mk(1, 0, 3'd5, 32'h100, 32'h0,        32'h80112233, 10, 2, 4'd0, 32'h0,       4'b0000, 1, 32'h00002233));
    vecs.push_back(mk(0, 1, 3'd0, 32'h201, 32'h000000A5, 32'h0,        2, 1, 4'd0, 32'hA5A5A5A5, 4'b0010, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd2, 32'h304, 32'hCAFEF00D, 32'h0,        2, 4, 4'd0, 32'hCAFEF00D, 4'b1111, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h101, 32'h0,        32'h0,        3, 1, 4'd4, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd2, 32'h302, 32'h0,        32'h0,        3, 1, 4'd6, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(1, 1, 3'd2, 32'h101, 32'h0,        32'h0,        3, 1, 4'd2, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h100, 32'h0,        32'h0,        3, 1, 4'd2, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd6, 32'h100, 32'h0,        32'h0,        3, 1, 4'd2, 32'h0,        4'b0000, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd0, 32'h001, 32'h0,        32'h0000FF00, 31, 1, 4'd0, 32'h0,       4'b0000, 1, 32'hFFFFFFFF));

    i_rst = 1'b1;
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    i_valid     = 1'b0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    check("rst_mem_bus", o_mem_addr | o_mem_wdata | {28'd0, o_mem_wstrb} | {31'd0, o_mem_we}, 32'd0);
    check("rst_wb", o_wb_data | {27'd0, o_wb_rd} | {31'd0, o_wb_valid}, 32'd0);
    check("rst_exc", o_exc_tval | {28'd0, o_exc_cause} | {31'd0, o_exc_valid} | {31'd0, o_done}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back: the second request waits on o_ready, then is accepted.
    wait_ready();
    drive_req(1'b1, 1'b0, LSU_W, 32'h10, 32'h0, 5'd3);
    @(negedge i_clk);
    drive_req(1'b0, 1'b1, LSU_W, 32'h20, 32'h11223344, 5'd0);
    check("b2b_ready_busy", {31'd0, o_ready}, 32'd0);
    check("b2b_first_addr", o_mem_addr, 32'h10);
    @(negedge i_clk);
    check("b2b_first_held", o_mem_addr, 32'h10);
    check("b2b_first_we", {31'd0, o_mem_we}, 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("b2b_done", {31'd0, o_done}, 32'd1);
    check("b2b_wb_data", o_wb_data, 32'h77);
    check("b2b_ready_still_busy", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    check("b2b_ready_back", {31'd0, o_ready}, 32'd1);
    check("b2b_not_yet_req", {31'd0, o_mem_req}, 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("b2b_second_req", {31'd0, o_mem_req}, 32'd1);
    check("b2b_second_we", {31'd0, o_mem_we}, 32'd1);
    check("b2b_second_addr", o_mem_addr, 32'h20);
    check("b2b_second_wdata", o_mem_wdata, 32'h11223344);
    check("b2b_second_wstrb", {28'd0, o_mem_wstrb}, 32'hF);
    i_mem_ack = 1'b1;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("b2b_second_done", {31'd0, o_done}, 32'd1);
    check("b2b_second_no_wb", {31'd0, o_wb_valid}, 32'd0);
    @(negedge i_clk);

    // Reset while the bus request is outstanding, then a stray ack.
    wait_ready();
    drive_req(1'b1, 1'b0, LSU_W, 32'h40, 32'h0, 5'd4);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rstmid_req_up", {31'd0, o_mem_req}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("rstmid_req_drop", {31'd0, o_mem_req}, 32'd0);
    check("rstmid_ready", {31'd0, o_ready}, 32'd1);
    check("rstmid_addr_clear", o_mem_addr, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h99;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("stray_ack_no_done", {31'd0, o_done}, 32'd0);
    check("stray_ack_no_wb", {31'd0, o_wb_valid}, 32'd0);
    check("stray_ack_no_req", {31'd0, o_mem_req}, 32'd0);
    check("stray_ack_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    check("stray_ack_no_done2", {31'd0, o_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
